// File: rtl/cal_pulse_counter.sv
// cal_pulse_counter: counts rising edges on NCH asynchronous calibration pulse lines (CLK40 domain).
//
// Ports:
//   CLK40         40 MHz clock; all logic on the rising edge
//   RST_RESYNC_B  synchronous active-low reset, highest priority
//   PLS_IN[NCH]   raw asynchronous pulse inputs
//   CLR[NCH]      per-channel clear of count, overflow and holdoff (level)
//   SNAP          strobe; copies all pre-update live counts into SNAP_OUT
//   CNT_OUT       live counts, channel i at [i*CNT_W +: CNT_W]
//   SNAP_OUT      snapshot counts, same packing as CNT_OUT
//   SNAP_VLD      one-cycle pulse the cycle after SNAP is accepted
//   OVFL[NCH]     sticky overflow flags
//   ANY_EDGE      registered OR of all counted edges
//   TMR_ERR       sticky triplet disagreement flag
//
// Optional feature: define CAL_PULSE_CNT_TMR_EN to triplicate the count, hold, overflow,
// snapshot and previous-value registers with majority voting; otherwise TMR_ERR is 0.
module cal_pulse_counter #(
   parameter int NCH         = 2,
   parameter int CNT_W       = 12,
   parameter int SYNC_STAGES = 2,
   parameter int HOLDOFF     = 0,
   parameter int SATURATE    = 0
) (
   input  logic                 CLK40,
   input  logic                 RST_RESYNC_B,
   input  logic [NCH-1:0]       PLS_IN,
   input  logic [NCH-1:0]       CLR,
   input  logic                 SNAP,
   output logic [NCH*CNT_W-1:0] CNT_OUT,
   output logic [NCH*CNT_W-1:0] SNAP_OUT,
   output logic                 SNAP_VLD,
   output logic [NCH-1:0]       OVFL,
   output logic                 ANY_EDGE,
   output logic                 TMR_ERR
);

`ifdef CAL_PULSE_CNT_TMR_EN
   localparam int R = 3;
`else
   localparam int R = 1;
`endif

   localparam logic [CNT_W-1:0] ONES = '1;

   // All state that is protected when triplication is enabled.
   typedef struct packed {
      logic [NCH-1:0]            prev;
      logic [NCH-1:0]            ovfl;
      logic [NCH-1:0][7:0]       hold;
      logic [NCH-1:0][CNT_W-1:0] snap;
      logic [NCH-1:0][CNT_W-1:0] cnt;
   } st_t;

   logic [NCH-1:0] sync_q [SYNC_STAGES];
   st_t            st_q [R];
   st_t            st_v, st_d, st_rst;
   logic [NCH-1:0] s, e;
   logic           vld_q, any_q;

   // Synchronizer loads ones on reset so a line already high at release is not an edge.
   always_ff @(posedge CLK40) begin
      if (!RST_RESYNC_B) begin
         for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '1;
      end else begin
         sync_q[0] <= PLS_IN;
         for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

`ifdef CAL_PULSE_CNT_TMR_EN
   logic err_q;
   assign st_v = (st_q[0] & st_q[1]) | (st_q[0] & st_q[2]) | (st_q[1] & st_q[2]);
   always_ff @(posedge CLK40) begin
      err_q <= RST_RESYNC_B & (err_q | (st_q[0] != st_q[1]) | (st_q[1] != st_q[2]));
   end
   assign TMR_ERR = err_q;
`else
   assign st_v    = st_q[0];
   assign TMR_ERR = 1'b0;
`endif

   always_comb begin
      st_rst      = '0;
      st_rst.prev = '1;
   end

   always_comb begin
      st_d = st_v;
      e    = '0;
      for (int i = 0; i < NCH; i++) begin
         e[i]         = s[i] & ~st_v.prev[i] & (st_v.hold[i] == 8'd0);
         st_d.prev[i] = s[i];
         // Clear beats a coincident edge; that edge is dropped, not deferred.
         if (CLR[i]) begin
            st_d.cnt[i]  = '0;
            st_d.ovfl[i] = 1'b0;
            st_d.hold[i] = 8'd0;
         end else if (e[i]) begin
            st_d.hold[i] = 8'(HOLDOFF);
            st_d.ovfl[i] = st_v.ovfl[i] | (st_v.cnt[i] == ONES);
            st_d.cnt[i]  = (st_v.cnt[i] == ONES && SATURATE != 0) ? ONES : st_v.cnt[i] + 1'b1;
         end else if (st_v.hold[i] != 8'd0) begin
            st_d.hold[i] = st_v.hold[i] - 8'd1;
         end
      end
      // Snapshot takes the counts as registered before this edge's update.
      if (SNAP) st_d.snap = st_v.cnt;
   end

   always_ff @(posedge CLK40) begin
      for (int r = 0; r < R; r++) st_q[r] <= RST_RESYNC_B ? st_d : st_rst;
      vld_q <= RST_RESYNC_B & SNAP;
      any_q <= RST_RESYNC_B & (|e);
   end

   assign CNT_OUT  = st_v.cnt;
   assign SNAP_OUT = st_v.snap;
   assign OVFL     = st_v.ovfl;
   assign SNAP_VLD = vld_q;
   assign ANY_EDGE = any_q;

endmodule

// File: doc/cal_pulse_counter.md
Name: cal_pulse_counter

Overview:
- Parametrised successor to the two-channel calibration pulse counter.
- Counts rising edges on NCH asynchronous calibration/injection pulse lines (raw skew-bus and LV trigger pulses).
- Adds an input synchronizer, per-channel holdoff, per-channel clear, wrap or saturate mode, sticky overflow flags, and an atomic snapshot of all counters for slow-control readout.
- Sits between the calibration pulse input buffers and the slow-control register file, in the CLK40 domain.

Parameters:
- NCH, 2, number of pulse channels (1..16).
- CNT_W, 12, counter width in bits (4..32).
- SYNC_STAGES, 2, synchronizer flops per channel (2..4).
- HOLDOFF, 0, dead-time cycles after a counted edge during which new edges on that channel are ignored (0..255).
- SATURATE, 0, overflow mode: 0 = wrap to 0; 1 = hold at all-ones.

Ports:
- CLK40  in  1  40 MHz system clock; all logic on the rising edge.
- RST_RESYNC_B  in  1  synchronous, active-low reset.
- PLS_IN  in  NCH  raw asynchronous pulse inputs, one per channel.
- CLR  in  NCH  per-channel clear strobe for count and OVFL; synchronous, level.
- SNAP  in  1  one-cycle strobe; latches all live counts into SNAP_OUT.
- CNT_OUT  out  NCH*CNT_W  live counts; channel i at bits [i*CNT_W +: CNT_W].
- SNAP_OUT  out  NCH*CNT_W  snapshot counts, same packing as CNT_OUT.
- SNAP_VLD  out  1  one-cycle pulse the cycle after SNAP is accepted.
- OVFL  out  NCH  sticky overflow flag per channel.
- ANY_EDGE  out  1  one-cycle strobe when any channel counts an edge this cycle.
- TMR_ERR  out  1  sticky triplication disagreement flag (see Optional Feature).

Behaviour:
- Reset (RST_RESYNC_B=0 at a clock edge):
  - CNT_OUT, SNAP_OUT, OVFL, SNAP_VLD, ANY_EDGE, TMR_ERR = 0.
  - Holdoff counters = 0.
  - Synchronizer and previous-value flops load all-ones, so an input already high at reset release is not counted.
  - Reset has priority over every other input.
- Synchronizer:
  - PLS_IN[i] passes through SYNC_STAGES flops to give s[i]; a further flop gives p[i].
  - Edge e[i] = s[i] & ~p[i] & (hold[i]==0).
- Latency: PLS_IN rising before clock edge k produces a CNT_OUT increment visible after edge k+SYNC_STAGES (3 cycles at default).
- Counting:
  - When e[i]=1, count[i] increments by 1.
  - Pulses shorter than one CLK40 period may be missed; this is not an error.
  - A level held high counts once.
- Holdoff:
  - On a counted edge, hold[i] loads HOLDOFF; it then decrements by 1 per cycle down to 0.
  - Edges seen while hold[i]!=0 are discarded permanently, not deferred.
  - HOLDOFF=0 disables holdoff.
- Overflow:
  - Increment from all-ones sets OVFL[i]=1.
  - SATURATE=0: count wraps to 0.
  - SATURATE=1: count stays all-ones.
  - OVFL[i] stays set until CLR[i] or reset.
- Clear:
  - CLR[i]=1 forces count[i]=0, OVFL[i]=0, hold[i]=0 on the next edge.
  - CLR wins over a simultaneous edge; that edge is lost.
- Snapshot:
  - SNAP=1 copies every channel's count, as registered before this edge's update, into SNAP_OUT; SNAP_VLD pulses for one cycle.
  - SNAP and an increment in the same cycle: snapshot holds the pre-increment value; live count increments.
  - SNAP and CLR in the same cycle: snapshot holds the pre-clear value.
  - SNAP_OUT holds its value until the next SNAP.
- ANY_EDGE: registered OR of e[] (after holdoff gating); asserted the same cycle the count increments; independent of CLR.
- Channels are fully independent; simultaneous edges on all channels all count.

Optional Feature:
- Macro: CAL_PULSE_CNT_TMR_EN.
- Defined:
  - Count, hold, OVFL, snapshot and previous-value registers are triplicated.
  - Each copy updates from the majority-voted value; outputs are driven from the voted value.
  - TMR_ERR is set sticky when any triplet disagrees at a clock edge, and cleared by reset only.
  - All other behaviour and latency are identical.
- Undefined: single copy of all registers; TMR_ERR tied to 0.

Test Plan:
- Reset with PLS_IN[0] held high, release, hold 20 cycles -> CNT_OUT ch0 = 0, ANY_EDGE never asserted.
- Default params, 5 clean pulses of 3 cycles each on ch1, 10 cycles apart -> ch1 = 5, ch0 = 0; each increment appears 3 cycles after the input rises.
- CNT_W=4, SATURATE=0, 17 pulses on ch0 -> count = 1, OVFL[0] = 1. Same with SATURATE=1 -> count = 15, OVFL[0] = 1. Then CLR[0] -> count = 0, OVFL[0] = 0.
- HOLDOFF=8, ch0 edges at relative cycles 0, 4, 9, 20 -> count = 3 (edge at cycle 4 discarded).
- Count ch0 = 7, then SNAP coincident with a counted edge on ch0 -> SNAP_OUT ch0 = 7, live = 8, SNAP_VLD high exactly 1 cycle. CLR[0] coincident with an edge -> count = 0.
- With CAL_PULSE_CNT_TMR_EN, force one copy of ch0 count to 0x5A5 while the others read 0x003 -> CNT_OUT ch0 = 0x003, TMR_ERR = 1 and held until reset.
